// File: rtl/uart_pkg.sv
// Shared UART frame format and receiver state encoding, used by both the RX and TX sides.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx line plus a registered falling-edge flag.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;

  // fall is computed from the value rx_s is about to take, so it lines up with rx_s itself
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      chain <= '1;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], rx};
      fall  <= chain[SYNC_STAGES-1] & ~chain[SYNC_STAGES-2];
    end
  end

  assign rx_s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_fsm.sv
// 8N1 UART receiver: 16x oversampled, centre-of-bit sampling, one-cycle valid/framing-error pulses.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 rx_en,
  input  logic                 bclk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  rx_state_t state, state_n;
  logic [TICK_W-1:0]    tick, tick_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n, data_n;
  logic                 valid_n, ferr_n;
  logic                 rx_s, fall;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .arst_n(arst_n),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      tick      <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      tick      <= tick_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
    end
  end

  // A bclk coinciding with the start edge is deliberately ignored: IDLE never advances tick
  always_comb begin
    state_n   = state;
    tick_n    = tick;
    bit_cnt_n = bit_cnt;
    shift_n   = shift_reg;
    data_n    = rx_data;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;

    if (state != IDLE && !rx_en) begin
      state_n   = IDLE;
      tick_n    = '0;
      bit_cnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          tick_n    = '0;
          bit_cnt_n = '0;
          if (rx_en && fall) state_n = START;
        end
        START: begin
          if (bclk) begin
            if (tick == HALF_TICK) begin
              tick_n  = '0;
              state_n = rx_s ? IDLE : DATA;
            end else begin
              tick_n = tick + 1'b1;
            end
          end
        end
        DATA: begin
          if (bclk) begin
            if (tick == LAST_TICK) begin
              tick_n  = '0;
              shift_n = {rx_s, shift_reg[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT) begin
                bit_cnt_n = '0;
                state_n   = STOP;
              end else begin
                bit_cnt_n = bit_cnt + 1'b1;
              end
            end else begin
              tick_n = tick + 1'b1;
            end
          end
        end
        STOP: begin
          if (bclk) begin
            if (tick == LAST_TICK) begin
              tick_n  = '0;
              state_n = IDLE;
              if (rx_s) begin
                data_n  = shift_reg;
                valid_n = 1'b1;
              end else begin
                ferr_n = 1'b1;
              end
            end else begin
              tick_n = tick + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
